// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, flag layout, FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        RA     = 4'd0,
        RB     = 4'd1,
        RADD   = 4'd2,
        RSUB   = 4'd3,
        RAND   = 4'd4,
        ROR    = 4'd5,
        RXOR   = 4'd6,
        RNOR   = 4'd7,
        RMULLO = 4'd8,
        RMULHI = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic c;
        logic v;
        logic nf;
        logic z;
    } flags_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } alu_state_t;

    function automatic logic is_mul(input alu_op_t op);
        return (op == RMULLO) || (op == RMULHI);
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned N x N shift-add multiplier, one partial product per step.
// Latency: N steps after load; product exposes the post-step accumulator value.
// Backpressure: none; the controller asserts step only while a multiply is in flight.
module shift_add_mul #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           last,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]   mcand;
    logic [N-1:0]   mplr;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   addend;
    logic [N:0]     sum_hi;
    logic [2*N-1:0] acc_nxt;

    always_comb begin
        addend  = mplr[0] ? mcand : '0;
        sum_hi  = {1'b0, acc[2*N-1:N]} + {1'b0, addend};
        // Shift {carry, acc} right by one as part of the same step.
        acc_nxt = {sum_hi, acc[N-1:1]};
    end

    // Product is the value the accumulator takes at this step, so on the
    // final step the caller can register the complete result at that edge.
    assign product = acc_nxt;
    assign last    = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            cnt   <= CW'(N);
        end else if (step) begin
            acc   <= acc_nxt;
            mplr  <= mplr >> 1;
            cnt   <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: eight single-cycle functions plus unsigned multiply lo/hi.
// Latency: 1 cycle for single-cycle ops, N+1 cycles for multiply.
// Backpressure: ready low while multiplying; start during that time is dropped.
module alu_mc
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   func,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);
    alu_state_t     state, state_nxt;
    alu_op_t        op, op_q;
    logic [N-1:0]   result_q;
    flags_t         flags_q;
    logic           accept, mul_op, load, step, last;
    logic [2*N-1:0] product;
    logic [N:0]     sum, diff;
    logic [N-1:0]   sc_res, mul_res;
    logic           sc_c, sc_v, sc_valid;
    flags_t         sc_flags, mul_flags;

    assign op     = alu_op_t'(func);
    assign mul_op = is_mul(op);
    assign ready  = (state != S_MUL);
    assign done   = (state == S_DONE);
    assign accept = ready && start;
    assign result = result_q;
    assign flags  = flags_q;

    shift_add_mul #(.N(N)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .a       (a),
        .b       (b),
        .last    (last),
        .product (product)
    );

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        sc_res   = '0;
        sc_c     = 1'b0;
        sc_v     = 1'b0;
        sc_valid = 1'b1;
        case (op)
            RA:   sc_res = a;
            RB:   sc_res = b;
            RADD: begin
                sc_res = sum[N-1:0];
                sc_c   = sum[N];
                sc_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            RSUB: begin
                sc_res = diff[N-1:0];
                sc_c   = diff[N];
                sc_v   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            RAND: sc_res = a & b;
            ROR:  sc_res = a | b;
            RXOR: sc_res = a ^ b;
            RNOR: sc_res = ~(a | b);
            default: sc_valid = 1'b0;
        endcase
        // Reserved codes report all-zero flags, including Z.
        sc_flags = '{c: sc_c, v: sc_v, nf: sc_res[N-1], z: sc_valid && (sc_res == '0)};

        mul_res   = (op_q == RMULHI) ? product[2*N-1:N] : product[N-1:0];
        mul_flags = '{c: |product[2*N-1:N], v: 1'b0, nf: mul_res[N-1], z: (mul_res == '0)};
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load      = mul_op;
                    state_nxt = mul_op ? S_MUL : S_DONE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL: begin
                step = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= RA;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) op_q <= op;
            if (accept && !mul_op) begin
                result_q <= sc_res;
                flags_q  <= sc_flags;
            end else if (step && last) begin
                result_q <= mul_res;
                flags_q  <= mul_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc with N = 8; expected values are hand-computed.
module tb_alu_mc;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] func = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       ready, done;
    logic [7:0] result;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;
    int done_cnt;
    int done_i;
    logic [7:0] done_res;

    alu_mc #(.N(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .func   (func),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input alu_op_t op, input logic [7:0] va, input logic [7:0] vb);
        start = s;
        func  = op;
        a     = va;
        b     = vb;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);

        // Back-to-back single-cycle ops; flags = {C,V,Nf,Z}
        drive(1'b1, RADD, 8'd5, 8'd17);
        tick();
        check("add_done", 32'(done), 32'd1);
        check("add_res", 32'(result), 32'd22);
        check("add_flags", 32'(flags), 32'b0000);
        drive(1'b1, RSUB, 8'd17, 8'd17);
        tick();
        check("sub0_done", 32'(done), 32'd1);
        check("sub0_res", 32'(result), 32'd0);
        check("sub0_flags", 32'(flags), 32'b0001);
        drive(1'b1, RSUB, 8'd5, 8'd17);
        tick();
        check("subneg_res", 32'(result), 32'd244);
        check("subneg_flags", 32'(flags), 32'b1010);
        drive(1'b1, RADD, 8'd127, 8'd1);
        tick();
        check("addov_res", 32'(result), 32'd128);
        check("addov_flags", 32'(flags), 32'b0110);
        drive(1'b1, RNOR, 8'h00, 8'h00);
        tick();
        check("nor_res", 32'(result), 32'hFF);
        check("nor_flags", 32'(flags), 32'b0010);
        drive(1'b1, RAND, 8'hF0, 8'h3C);
        tick();
        check("and_res", 32'(result), 32'h30);
        drive(1'b1, RXOR, 8'h0F, 8'hFF);
        tick();
        check("xor_res", 32'(result), 32'hF0);
        drive(1'b0, RA, 8'd0, 8'd0);
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_hold", 32'(result), 32'hF0);

        // RMULLO 13 x 11 = 143
        drive(1'b1, RMULLO, 8'd13, 8'd11);
        tick();
        drive(1'b0, RA, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mullo_busy%0d", i), 32'({ready, done}), 32'b00);
            tick();
        end
        check("mullo_done", 32'(done), 32'd1);
        check("mullo_ready", 32'(ready), 32'd1);
        check("mullo_res", 32'(result), 32'd143);
        check("mullo_flags", 32'(flags), 32'b0010);

        // RMULHI 200 x 200 = 0x9C40
        drive(1'b1, RMULHI, 8'd200, 8'd200);
        tick();
        drive(1'b0, RA, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) tick();
        check("mulhi_done", 32'(done), 32'd1);
        check("mulhi_res", 32'(result), 32'h9C);
        check("mulhi_flags", 32'(flags), 32'b1010);

        // start asserted mid-multiply must be ignored; operands changed too
        drive(1'b1, RMULLO, 8'd13, 8'd11);
        tick();
        done_cnt = 0;
        done_i   = -1;
        done_res = 8'd0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) drive(1'b1, RADD, 8'd1, 8'd1);
            else        drive(1'b0, RMULHI, 8'd255, 8'd255);
            tick();
            if (done) begin
                done_cnt++;
                done_i   = i;
                done_res = result;
            end
        end
        check("ignore_pulses", 32'(done_cnt), 32'd1);
        check("ignore_when", 32'(done_i), 32'd7);
        check("ignore_res", 32'(done_res), 32'd143);

        // Reset in MUL cycle 4 aborts
        drive(1'b1, RMULLO, 8'd13, 8'd11);
        tick();
        drive(1'b0, RA, 8'd0, 8'd0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_res", 32'(result), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        drive(1'b1, RA, 8'd9, 8'd3);
        tick();
        check("ra_done", 32'(done), 32'd1);
        check("ra_res", 32'(result), 32'd9);
        check("ra_flags", 32'(flags), 32'b0000);

        // Reserved op: result and every flag zero
        drive(1'b1, alu_op_t'(4'd12), 8'd5, 8'd17);
        tick();
        check("rsv_done", 32'(done), 32'd1);
        check("rsv_res", 32'(result), 32'd0);
        check("rsv_flags", 32'(flags), 32'd0);

        // Reset and start on the same edge: request dropped
        drive(1'b1, RADD, 8'd5, 8'd17);
        tick();
        drive(1'b1, RADD, 8'd7, 8'd7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, RA, 8'd0, 8'd0);
        check("rststart_done", 32'(done), 32'd0);
        check("rststart_res", 32'(result), 32'd0);
        tick();
        check("rststart_after", 32'({done, result}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
